// File: rtl/processor.sv
// 8-bit accumulator processor running a fixed 16-word ROM, one instruction per divider period.
// Output is a combinational mode-selected view of ACC, a register, IR or PC.
module processor #(
  parameter int DIV_BITS = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pause,
  input  logic [4:0] i_mode,
  output logic       o_cb,
  output logic [7:0] o_output,
  output logic       o_slow_clk,
  output logic [3:0] o_pc
);
  localparam logic [DIV_BITS-1:0] DIV_ONE = DIV_BITS'(1);

  logic [DIV_BITS-1:0] r_div_cnt;
  logic [3:0]          r_pc;
  logic [7:0]          r_acc;
  logic                r_cb;
  logic [7:0]          r_regs [16];
  logic                r_halted;

  logic [7:0] w_ir;
  logic [3:0] w_op;
  logic [3:0] w_x;
  logic [7:0] w_rx;
  logic [8:0] w_sum;
  logic       w_tick;
  logic       w_exec;
  logic [3:0] w_pc_nxt;
  logic [7:0] w_acc_nxt;
  logic       w_cb_nxt;
  logic       w_reg_we;
  logic       w_halt_nxt;

  always_comb begin
    case (r_pc)
      4'd0:    w_ir = 8'h71;
      4'd1:    w_ir = 8'h31;
      4'd2:    w_ir = 8'h70;
      4'd3:    w_ir = 8'h11;
      4'd4:    w_ir = 8'hA6;
      4'd5:    w_ir = 8'h83;
      4'd6:    w_ir = 8'hFF;
      default: w_ir = 8'h00;
    endcase
  end

  assign w_op   = w_ir[7:4];
  assign w_x    = w_ir[3:0];
  assign w_rx   = r_regs[w_x];
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_rx};
  assign w_tick = &r_div_cnt;
  assign w_exec = w_tick & ~i_pause & ~r_halted;

  // Unlisted opcodes fall through to the defaults and act as NOP.
  always_comb begin
    w_pc_nxt   = r_pc + 4'd1;
    w_acc_nxt  = r_acc;
    w_cb_nxt   = r_cb;
    w_reg_we   = 1'b0;
    w_halt_nxt = r_halted;
    case (w_op)
      4'h1: begin
        w_acc_nxt = w_sum[7:0];
        w_cb_nxt  = w_sum[8];
      end
      4'h2: begin
        w_acc_nxt = r_acc - w_rx;
        w_cb_nxt  = (w_rx > r_acc);
      end
      4'h3: w_reg_we  = 1'b1;
      4'h4: w_acc_nxt = w_rx;
      4'h5: w_acc_nxt = r_acc & w_rx;
      4'h6: w_acc_nxt = r_acc ^ w_rx;
      4'h7: w_acc_nxt = {4'b0, w_x};
      4'h8: w_pc_nxt  = w_x;
      4'h9: if (r_acc == 8'd0) w_pc_nxt = w_x;
      4'hA: if (r_cb) w_pc_nxt = w_x;
      4'hB: begin
        if (w_x == 4'h0) begin
          w_cb_nxt  = r_acc[7];
          w_acc_nxt = {r_acc[6:0], 1'b0};
        end else if (w_x == 4'h1) begin
          w_cb_nxt  = r_acc[0];
          w_acc_nxt = {1'b0, r_acc[7:1]};
        end
      end
      4'hF: begin
        if (w_x == 4'hF) begin
          w_halt_nxt = 1'b1;
          w_pc_nxt   = r_pc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_div_cnt <= '0;
    else          r_div_cnt <= r_div_cnt + DIV_ONE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc     <= 4'd0;
      r_acc    <= 8'd0;
      r_cb     <= 1'b0;
      r_halted <= 1'b0;
      for (int i = 0; i < 16; i++) r_regs[i] <= 8'd0;
    end else if (w_exec) begin
      r_pc     <= w_pc_nxt;
      r_acc    <= w_acc_nxt;
      r_cb     <= w_cb_nxt;
      r_halted <= w_halt_nxt;
      if (w_reg_we) r_regs[w_x] <= r_acc;
    end
  end

  always_comb begin
    o_output = r_acc;
    if (!i_mode[4])               o_output = r_regs[i_mode[3:0]];
    else if (i_mode == 5'b10000)  o_output = w_ir;
    else if (i_mode == 5'b10001)  o_output = {4'b0, r_pc};
  end

  assign o_cb       = r_cb;
  assign o_pc       = r_pc;
  assign o_slow_clk = r_div_cnt[DIV_BITS-1];
endmodule

// File: tb/tb_processor.sv
// Randomized bench for processor: an instruction-level interpreter predicts every output.
module tb_processor;
  localparam int DIVN = 4;

  logic       clk;
  logic       rstn;
  logic       pause;
  logic [4:0] mode;
  logic       cb;
  logic [7:0] out;
  logic       slow;
  logic [3:0] pc;

  int n_chk  = 0;
  int n_fail = 0;

  processor #(.DIV_BITS(2)) dut (
    .i_clk(clk), .i_rst_n(rstn), .i_pause(pause), .i_mode(mode),
    .o_cb(cb), .o_output(out), .o_slow_clk(slow), .o_pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: instruction-level interpreter driven by edge count since reset.
  int rom [16];
  int m_r [16];
  int m_acc, m_cb, m_pc, m_halt, m_n;

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 0;
    rom[0] = 'h71; rom[1] = 'h31; rom[2] = 'h70; rom[3] = 'h11;
    rom[4] = 'hA6; rom[5] = 'h83; rom[6] = 'hFF;
  end

  task automatic model_exec();
    int op, x, npc, s;
    op  = rom[m_pc] / 16;
    x   = rom[m_pc] % 16;
    npc = (m_pc + 1) % 16;
    case (op)
      1: begin s = m_acc + m_r[x]; m_cb = (s > 255); m_acc = s % 256; end
      2: begin m_cb = (m_r[x] > m_acc); m_acc = (m_acc - m_r[x] + 256) % 256; end
      3: m_r[x] = m_acc;
      4: m_acc = m_r[x];
      5: m_acc = m_acc & m_r[x];
      6: m_acc = m_acc ^ m_r[x];
      7: m_acc = x;
      8: npc = x;
      9: if (m_acc == 0) npc = x;
      10: if (m_cb != 0) npc = x;
      11: begin
        if (x == 0) begin m_cb = (m_acc >= 128); m_acc = (m_acc * 2) % 256; end
        else if (x == 1) begin m_cb = m_acc % 2; m_acc = m_acc / 2; end
      end
      15: if (x == 15) begin m_halt = 1; npc = m_pc; end
      default: ;
    endcase
    m_pc = npc;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_acc = 0; m_cb = 0; m_pc = 0; m_halt = 0; m_n = 0;
      for (int i = 0; i < 16; i++) m_r[i] = 0;
    end else begin
      m_n++;
      if ((m_n % DIVN) == 0 && !pause && m_halt == 0) model_exec();
    end
  end

  function automatic int exp_out(input logic [4:0] md);
    if (!md[4])            return m_r[md[3:0]];
    else if (md == 5'h10)  return rom[m_pc];
    else if (md == 5'h11)  return m_pc;
    else                   return m_acc;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_pc"},   pc,   m_pc);
    check({tag, "_cb"},   cb,   m_cb);
    check({tag, "_slow"}, slow, ((m_n % DIVN) >= DIVN / 2) ? 1 : 0);
    check({tag, "_out"},  out,  exp_out(mode));
  endtask

  // One clock: drive at the falling edge, compare shortly after, away from posedge.
  task automatic step(input string tag, input int pause_pct);
    @(negedge clk);
    mode = 5'($urandom_range(0, 31));
    if (pause_pct >= 0) pause = ($urandom_range(0, 99) < pause_pct);
    #1 check_all(tag);
  endtask

  int pc_hold, out_hold, seen_wrap, budget;

  initial begin
    rstn = 1'b0; pause = 1'b0; mode = 5'h1f;
    #1 check_all("reset");
    check("reset_out_acc", out, 0);
    #12 rstn = 1'b1;

    // Startup: first tick on the fourth rising edge.
    mode = 5'h11;
    repeat (3) begin @(negedge clk); #1 check("startup_pc0", pc, 0); end
    @(negedge clk); #1 check("startup_pc1", pc, 1);
    mode = 5'h1f; #1 check("startup_acc1", out, 1);

    repeat (60) step("run", 0);

    // Directed pause of ten ticks: state must freeze then resume.
    @(negedge clk); mode = 5'h1f;
    pause = 1'b1;
    #1 pc_hold = pc; out_hold = out;
    repeat (40) begin
      @(negedge clk); #1;
      check("pause_pc", pc, pc_hold);
      check("pause_out", out, out_hold);
      check_all("pause");
    end
    pause = 1'b0;
    repeat (40) step("resume", 0);

    repeat (300) step("rpause", 30);
    pause = 1'b0;

    // Run to completion, watching for the 255 -> 0 carry wrap.
    seen_wrap = 0; budget = 5000;
    while (m_halt == 0 && budget > 0) begin
      step("long", 0);
      if (m_acc == 0 && m_cb == 1) seen_wrap = 1;
      budget--;
    end
    check("halt_reached", m_halt, 1);
    check("wrap_seen", seen_wrap, 1);
    repeat (40) begin
      step("halted", 0);
      check("halted_pc", pc, 6);
      check("halted_cb", cb, 1);
    end

    // Asynchronous reset between edges, then restart from PC 0.
    @(negedge clk); #2 rstn = 1'b0;
    #1 mode = 5'h1f;
    #0 check_all("arst");
    check("arst_out", out, 0);
    #1 rstn = 1'b1;
    repeat (3) begin @(negedge clk); #1 check("restart_pc0", pc, 0); end
    @(negedge clk); #1 check("restart_pc1", pc, 1);
    repeat (80) step("restart", 0);

    // Register view after the MOVA has executed.
    @(negedge clk); mode = 5'h01; #1 check("mode_r1", out, 1);
    mode = 5'h02; #1 check("mode_r2", out, 0);
    mode = 5'h10; #1 check("mode_ir", out, rom[m_pc]);
    mode = 5'h11; #1 check("mode_pc", out, m_pc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
